switch_input_handshake: RTL and testbench

Input-side counterpart of the display output path. It serves the CPU's IN instruction: it holds the PC (stall) while an IN is pending, waits for a debounced "confirm" button press, then captures the synchronized 16-bit switch value and releases the CPU for exactly one cycle. It sits between the board switches/button and the In Signal MUX / PC hold logic in the top-level CPU.

---
 rtl/switch_input_handshake_pkg.sv | 27 ++
 rtl/switch_input_handshake_if.sv | 36 +++
 rtl/switch_input_handshake_in_debouncer.sv | 67 ++++++
 rtl/switch_input_handshake.sv | 124 ++++++++++++
 tb/tb_switch_input_handshake.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/switch_input_handshake_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switch_input_pkg
// Description : Shared types and helpers for the switch input handshake block.
//               - in_state_t         : handshake FSM state encoding
//               - DEFAULT_DATA_WIDTH : default switch/data bus width
//               - debounce_cnt_width : width of the debounce counter
// Revision    : 1.0 - initial release
// ============================================================================
package switch_input_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WAIT_PRESS   = 2'd1,
        ST_WAIT_RELEASE = 2'd2
    } in_state_t;

    // The counter only has to reach DEBOUNCE_CYCLES-1 before it clears, so
    // clog2 bits suffice. The floor of one bit keeps tiny settings legal.
    function automatic int debounce_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage : switch_input_pkg
`default_nettype wire

// File: rtl/switch_input_handshake_if.sv
`default_nettype none
// ============================================================================
// Module      : switch_input_handshake_if
// Description : Bundle between the board/CPU side and the input handshake.
//   switches    : raw board switches (asynchronous)
//   confirm_btn : raw confirm push button, active-high, bouncy
//   cu_inSignal : control unit flags the current instruction as IN
//   in_data     : captured switch value for the In Signal MUX
//   in_valid    : one-cycle pulse, in_data is fresh
//   in_stall    : hold PC / suppress register write while IN is pending
//   in_waiting  : LED, CPU waits for a confirm press
//   modport master : board/CPU side; modport slave : handshake block
// Revision    : 1.0 - initial release
// ============================================================================
interface switch_input_handshake_if #(
    parameter int DATA_WIDTH = switch_input_pkg::DEFAULT_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] switches;
    logic                  confirm_btn;
    logic                  cu_inSignal;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_stall;
    logic                  in_waiting;

    modport master (
        output switches, confirm_btn, cu_inSignal,
        input  in_data, in_valid, in_stall, in_waiting
    );

    modport slave (
        input  switches, confirm_btn, cu_inSignal,
        output in_data, in_valid, in_stall, in_waiting
    );
endinterface : switch_input_handshake_if
`default_nettype wire

// File: rtl/switch_input_handshake_in_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : in_debouncer
// Description : Synchronizer plus stability counter for one push button.
//               Emits one-cycle pulses on the debounced rising/falling edge.
//   clock     : system clock, rising edge
//   reset     : asynchronous active-low reset
//   i_btn     : raw button level (asynchronous)
//   o_press   : one-cycle pulse on debounced 0->1
//   o_release : one-cycle pulse on debounced 1->0
// Revision    : 1.0 - initial release
// ============================================================================
module in_debouncer
    import switch_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic i_btn,
    output logic      o_press,
    output logic      o_release
);

    localparam int            CW     = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] C_TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level;
    logic [CW-1:0]          r_cnt;
    logic                   r_press;
    logic                   r_release;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync    <= '0;
            r_level   <= 1'b0;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (w_sync == r_level) begin
                // Any return to the accepted level restarts the stability window.
                r_cnt <= '0;
            end else if (r_cnt == C_TERM) begin
                r_level   <= w_sync;
                r_cnt     <= '0;
                r_press   <= w_sync;
                r_release <= ~w_sync;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press   = r_press;
    assign o_release = r_release;

endmodule : in_debouncer
`default_nettype wire

// File: rtl/switch_input_handshake.sv
`default_nettype none
// ============================================================================
// Module      : switch_input_handshake
// Description : Serves the CPU IN instruction. Stalls while IN is pending,
//               waits for a debounced confirm press, captures the synchronized
//               switches and pulses in_valid for one cycle.
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : switch_input_handshake_if.slave (switches, button, IN request,
//           captured data, valid pulse, stall, waiting LED)
// Build option : define IN_PREFETCH_EN to add a one-entry buffer that stores a
//                press made while no IN is pending.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_input_handshake
    import switch_input_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  wire logic               clock,
    input  wire logic               reset,
    switch_input_handshake_if.slave bus
);

    in_state_t             r_state;
    logic [DATA_WIDTH-1:0] r_in_data;
    logic                  r_in_valid;
    logic [DATA_WIDTH-1:0] r_sw_sync [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] w_sw;
    logic                  w_press;
    logic                  w_release;
`ifdef IN_PREFETCH_EN
    logic [DATA_WIDTH-1:0] r_buf;
    logic                  r_buf_full;
`endif

    in_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_debouncer (
        .clock     (clock),
        .reset     (reset),
        .i_btn     (bus.confirm_btn),
        .o_press   (w_press),
        .o_release (w_release)
    );

    // Switches are only ever sampled, never edge-detected, so a plain
    // multi-stage sync is enough; the press event marks the sample point.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sw_sync[i] <= '0;
        end else begin
            r_sw_sync[0] <= bus.switches;
            for (int i = 1; i < SYNC_STAGES; i++) r_sw_sync[i] <= r_sw_sync[i-1];
        end
    end

    assign w_sw = r_sw_sync[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_in_data  <= '0;
            r_in_valid <= 1'b0;
`ifdef IN_PREFETCH_EN
            r_buf      <= '0;
            r_buf_full <= 1'b0;
`endif
        end else begin
            r_in_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // In the valid cycle the completing IN is still asserted;
                    // ignore it so it is not taken as a fresh request.
`ifdef IN_PREFETCH_EN
                    if (bus.cu_inSignal && !r_in_valid && r_buf_full) begin
                        r_in_data  <= r_buf;
                        r_in_valid <= 1'b1;
                        r_buf_full <= 1'b0;
                    end else if (bus.cu_inSignal && !r_in_valid) begin
                        r_state <= ST_WAIT_PRESS;
                    end
                    // Latest press wins, even over a same-cycle delivery.
                    if (w_press) begin
                        r_buf      <= w_sw;
                        r_buf_full <= 1'b1;
                    end
`else
                    if (bus.cu_inSignal && !r_in_valid) begin
                        r_state <= ST_WAIT_PRESS;
                    end
`endif
                end
                ST_WAIT_PRESS: begin
                    if (!bus.cu_inSignal) begin
                        r_state <= ST_IDLE;
                    end else if (w_press) begin
                        r_in_data  <= w_sw;
                        r_in_valid <= 1'b1;
                        r_state    <= ST_WAIT_RELEASE;
                    end
                end
                ST_WAIT_RELEASE: begin
                    // One press completes one IN: a held button must be
                    // released before the next request can be served.
                    if (w_release) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_data    = r_in_data;
    assign bus.in_valid   = r_in_valid;
    assign bus.in_stall   = bus.cu_inSignal & ~r_in_valid;
    assign bus.in_waiting = (r_state == ST_WAIT_PRESS);

endmodule : switch_input_handshake
`default_nettype wire

// File: tb/tb_switch_input_handshake.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_input_handshake
// Description : Self-checking bench for switch_input_handshake with
//               DEBOUNCE_CYCLES=4 and SYNC_STAGES=2. Directed vectors from a
//               table plus hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_input_handshake;

    logic clock;
    logic reset;
    int   checks     = 0;
    int   errors     = 0;
    int   valid_cnt  = 0;
    int   cnt_before;

    switch_input_handshake_if #(.DATA_WIDTH(16)) bus ();

    switch_input_handshake #(
        .DATA_WIDTH      (16),
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset && bus.in_valid) valid_cnt = valid_cnt + 1;
    end

    typedef struct {
        logic [15:0] sw;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs [4];

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Returns at the negedge where in_valid is high, or flags a timeout.
    task automatic wait_valid(input string name, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (bus.in_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_valid_seen"}, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{sw: 16'h00A5, exp_data: 16'h00A5};
        vecs[1] = '{sw: 16'hFFFF, exp_data: 16'hFFFF};
        vecs[2] = '{sw: 16'h8001, exp_data: 16'h8001};
        vecs[3] = '{sw: 16'h7E3C, exp_data: 16'h7E3C};

        // ---------------- reset state ----------------
        reset               = 1'b0;
        bus.switches        = 16'h0000;
        bus.confirm_btn     = 1'b0;
        bus.cu_inSignal     = 1'b0;
        tick(3);
        @(negedge clock);
        check("rst_data",    {16'd0, bus.in_data}, 32'h0);
        check("rst_valid",   {31'd0, bus.in_valid}, 32'h0);
        check("rst_waiting", {31'd0, bus.in_waiting}, 32'h0);
        check("rst_stall0",  {31'd0, bus.in_stall}, 32'h0);
        bus.cu_inSignal = 1'b1;
        #1;
        check("rst_stall1",  {31'd0, bus.in_stall}, 32'h1);
        bus.cu_inSignal = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(3);

        // ---------------- basic IN transactions ----------------
        for (int v = 0; v < 4; v++) begin
            cnt_before   = valid_cnt;
            bus.switches = ~vecs[v].sw;
            bus.cu_inSignal = 1'b1;
            tick(3);
            check("basic_waiting", {31'd0, bus.in_waiting}, 32'h1);
            check("basic_stall",   {31'd0, bus.in_stall}, 32'h1);
            bus.switches = vecs[v].sw;
            tick(10);
            check("sw_change_no_event", valid_cnt, cnt_before);
            bus.confirm_btn = 1'b1;
            wait_valid("basic", 30);
            check("basic_data",        {16'd0, bus.in_data}, {16'd0, vecs[v].exp_data});
            check("basic_stall_valid", {31'd0, bus.in_stall}, 32'h0);
            @(posedge clock); #1;
            bus.cu_inSignal = 1'b0;
            @(negedge clock);
            check("basic_one_pulse", {31'd0, bus.in_valid}, 32'h0);
            check("basic_waiting_after", {31'd0, bus.in_waiting}, 32'h0);
            tick(1);
            bus.confirm_btn = 1'b0;
            tick(15);
            check("basic_count", valid_cnt, cnt_before + 1);
            check("basic_data_hold", {16'd0, bus.in_data}, {16'd0, vecs[v].exp_data});
        end

        // ---------------- bouncing button ----------------
        cnt_before      = valid_cnt;
        bus.switches    = 16'h5A5A;
        bus.cu_inSignal = 1'b1;
        tick(2);
        for (int i = 0; i < 10; i++) begin
            bus.confirm_btn = ~bus.confirm_btn;
            tick(2);
        end
        check("bounce_no_capture", valid_cnt, cnt_before);
        check("bounce_waiting", {31'd0, bus.in_waiting}, 32'h1);
        bus.confirm_btn = 1'b1;
        wait_valid("bounce", 30);
        check("bounce_data", {16'd0, bus.in_data}, 32'h5A5A);
        @(posedge clock); #1;
        bus.cu_inSignal = 1'b0;
        tick(20);
        check("bounce_single", valid_cnt, cnt_before + 1);

        // ---------------- hold-and-reissue (button still held) ----------------
        cnt_before      = valid_cnt;
        bus.cu_inSignal = 1'b1;
        tick(20);
        check("reissue_stall",    {31'd0, bus.in_stall}, 32'h1);
        check("reissue_no_valid", valid_cnt, cnt_before);
        check("reissue_not_wait", {31'd0, bus.in_waiting}, 32'h0);
        bus.confirm_btn = 1'b0;
        tick(15);
        check("reissue_waiting", {31'd0, bus.in_waiting}, 32'h1);
        bus.switches    = 16'h1234;
        bus.confirm_btn = 1'b1;
        wait_valid("reissue", 30);
        check("reissue_data", {16'd0, bus.in_data}, 32'h1234);
        @(posedge clock); #1;
        bus.cu_inSignal = 1'b0;
        bus.confirm_btn = 1'b0;
        tick(15);
        check("reissue_count", valid_cnt, cnt_before + 1);

`ifdef IN_PREFETCH_EN
        // ---------------- prefetch buffer ----------------
        cnt_before      = valid_cnt;
        bus.switches    = 16'hBEEF;
        bus.confirm_btn = 1'b1;
        tick(12);
        bus.confirm_btn = 1'b0;
        tick(12);
        check("pf_no_early_valid", valid_cnt, cnt_before);
        bus.cu_inSignal = 1'b1;
        @(negedge clock);
        check("pf_stall_cycle", {31'd0, bus.in_stall}, 32'h1);
        check("pf_valid_low",   {31'd0, bus.in_valid}, 32'h0);
        @(negedge clock);
        check("pf_valid",       {31'd0, bus.in_valid}, 32'h1);
        check("pf_data",        {16'd0, bus.in_data}, 32'hBEEF);
        check("pf_stall_valid", {31'd0, bus.in_stall}, 32'h0);
        @(posedge clock); #1;
        bus.cu_inSignal = 1'b0;
        tick(5);
        for (int p = 1; p <= 2; p++) begin
            bus.switches    = 16'(p);
            bus.confirm_btn = 1'b1;
            tick(12);
            bus.confirm_btn = 1'b0;
            tick(12);
        end
        bus.cu_inSignal = 1'b1;
        wait_valid("pf2", 5);
        check("pf_latest_wins", {16'd0, bus.in_data}, 32'h0002);
        @(posedge clock); #1;
        bus.cu_inSignal = 1'b0;
        tick(5);
`else
        // ---------------- press without request ----------------
        cnt_before      = valid_cnt;
        bus.switches    = 16'hDEAD;
        bus.confirm_btn = 1'b1;
        tick(12);
        bus.confirm_btn = 1'b0;
        tick(12);
        check("idle_press_no_valid", valid_cnt, cnt_before);
        check("idle_press_data",     {16'd0, bus.in_data}, 32'h1234);
        bus.cu_inSignal = 1'b1;
        tick(20);
        check("idle_press_stall",   {31'd0, bus.in_stall}, 32'h1);
        check("idle_press_pending", valid_cnt, cnt_before);
        check("idle_press_data2",   {16'd0, bus.in_data}, 32'h1234);
        bus.switches    = 16'h0F0F;
        bus.confirm_btn = 1'b1;
        wait_valid("idle_press_new", 30);
        check("idle_press_new_data", {16'd0, bus.in_data}, 32'h0F0F);
        @(posedge clock); #1;
        bus.cu_inSignal = 1'b0;
        bus.confirm_btn = 1'b0;
        tick(15);
`endif

        // ---------------- async reset while waiting ----------------
        bus.cu_inSignal = 1'b1;
        tick(5);
        check("ar_waiting_before", {31'd0, bus.in_waiting}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_data",    {16'd0, bus.in_data}, 32'h0);
        check("ar_valid",   {31'd0, bus.in_valid}, 32'h0);
        check("ar_idle",    {31'd0, bus.in_waiting}, 32'h0);
        check("ar_stall_1", {31'd0, bus.in_stall}, 32'h1);
        bus.cu_inSignal = 1'b0;
        #1;
        check("ar_stall_0", {31'd0, bus.in_stall}, 32'h0);
        bus.cu_inSignal = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(3);
        check("ar_resume_wait",  {31'd0, bus.in_waiting}, 32'h1);
        check("ar_resume_stall", {31'd0, bus.in_stall}, 32'h1);
        bus.cu_inSignal = 1'b0;
        tick(3);
        check("ar_final_idle", {31'd0, bus.in_waiting}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_switch_input_handshake
`default_nettype wire
